// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and ROM-latency alignment for the IF stage,
// with stall replay and zero-bubble redirect.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_instr,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_instr,
    output logic              misalign_err,
    output logic [31:0]       fetch_count
);
    logic [31:0] pc_q, pc_d, if_pc_q, if_pc_d, cnt_q, cnt_d, tgt;
    logic        valid_q, valid_d, misalign_q, misalign_d, hold;

    always_comb begin
        tgt        = {redirect_pc[31:2], 2'b00};
        hold       = stall && valid_q && !redirect_valid;
        // A held stall re-reads the current word so rom_instr stays stable.
        rom_addr   = redirect_valid ? redirect_pc[ADDR_W+1:2] :
                     (stall && valid_q) ? if_pc_q[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
        if_pc_d    = hold ? if_pc_q : redirect_valid ? tgt : pc_q;
        pc_d       = hold ? pc_q : redirect_valid ? tgt + 32'd4 : pc_q + 32'd4;
        valid_d    = hold ? valid_q : 1'b1;
        misalign_d = misalign_q || (redirect_valid && (redirect_pc[1:0] != 2'b00));
        cnt_d      = hold ? cnt_q : cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= PC_RESET;
            if_pc_q    <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    // ROM output is undefined until the first real fetch, so mask it with a NOP.
    assign if_valid     = valid_q;
    assign if_pc        = if_pc_q;
    assign if_instr     = valid_q ? rom_instr : 32'h0000_0013;
    assign misalign_err = misalign_q;
    assign fetch_count  = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a synchronous ROM model.
module tb_fetch_unit;
    logic        clk, rst_n, stall, redirect_valid;
    logic [31:0] redirect_pc, rom_instr, if_pc, if_instr, fetch_count;
    logic [9:0]  rom_addr;
    logic        if_valid, misalign_err;
    logic [31:0] rom [1024];
    int          total = 0;
    int          passed = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr), .rom_instr(rom_instr),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    always @(posedge clk) rom_instr <= rom[rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] cnt);
        check({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
        check({tag, ".pc"}, if_pc, pc);
        check({tag, ".instr"}, if_instr, ins);
        check({tag, ".count"}, fetch_count, cnt);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0000_0000 + i;
        rom[0]    = 32'h0015_0393;
        rom[1]    = 32'h0024_8413;
        rom[2]    = 32'h0083_85B3;
        rom[6]    = 32'h0033_8A13;
        rom[7]    = 32'h0000_0513;
        rom[1023] = 32'hFFF0_0093;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(); step();
        check("rst.valid", {31'd0, if_valid}, 32'd0);
        check("rst.pc", if_pc, 32'h0);
        check("rst.instr", if_instr, 32'h13);
        check("rst.misalign", {31'd0, misalign_err}, 32'd0);
        check("rst.count", fetch_count, 32'd0);
        rst_n = 1'b1;
        #1;
        check("boot.bubble", {31'd0, if_valid}, 32'd0);
        step(); expect_out("run0", 32'h0, 32'h0015_0393, 32'd1);
        step(); expect_out("run1", 32'h4, 32'h0024_8413, 32'd2);
        // Stall three edges while the word at PC 4 is on the output.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_out("stall", 32'h4, 32'h0024_8413, 32'd2);
        end
        stall = 1'b0;
        step(); expect_out("release", 32'h8, 32'h0083_85B3, 32'd3);
        redirect_valid = 1'b1; redirect_pc = 32'h18;
        step(); expect_out("redir", 32'h18, 32'h0033_8A13, 32'd4);
        redirect_valid = 1'b0;
        step(); expect_out("redir+1", 32'h1C, 32'h0000_0513, 32'd5);
        redirect_valid = 1'b1; redirect_pc = 32'h0; stall = 1'b1;
        step(); expect_out("redir_stall", 32'h0, 32'h0015_0393, 32'd6);
        redirect_valid = 1'b0; stall = 1'b0;
        step(); expect_out("redir_stall+1", 32'h4, 32'h0024_8413, 32'd7);
        check("pre_misalign", {31'd0, misalign_err}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0FFE;
        step(); expect_out("mis", 32'hFFC, 32'hFFF0_0093, 32'd8);
        check("mis.flag", {31'd0, misalign_err}, 32'd1);
        redirect_valid = 1'b0;
        step(); expect_out("wrap", 32'h1000, 32'h0015_0393, 32'd9);
        check("wrap.flag", {31'd0, misalign_err}, 32'd1);
        step(); expect_out("wrap+1", 32'h1004, 32'h0024_8413, 32'd10);
        check("sticky", {31'd0, misalign_err}, 32'd1);
        // Asynchronous reset pulse between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("areset.valid", {31'd0, if_valid}, 32'd0);
        check("areset.pc", if_pc, 32'h0);
        check("areset.instr", if_instr, 32'h13);
        check("areset.count", fetch_count, 32'd0);
        check("areset.misalign", {31'd0, misalign_err}, 32'd0);
        #4 rst_n = 1'b1;
        step(); expect_out("restart0", 32'h0, 32'h0015_0393, 32'd1);
        step(); expect_out("restart1", 32'h4, 32'h0024_8413, 32'd2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that drives the word-indexed, synchronous-read instruction ROM and consumes its registered `instr` output. It maintains the program counter and issues `rom_addr = PC >> 2` every cycle. It aligns the one-cycle ROM read latency with the PC that produced each word, and presents a `{valid, pc, instr}` triple to decode. It supports pipeline stall (hold and replay) and branch/jump redirect, sits between the ROM and the IF/ID boundary, and adds zero bubbles on stall release.

## Interface
- `PC_RESET`, default 32'h0000_0000: first fetch address after reset.
- `ADDR_W`, default 10: ROM word-index width (1024 words).
- `clk` in 1: rising-edge clock; the ROM shares it.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard unit holds the fetch output.
- `redirect_valid` in 1: taken branch or jump this cycle.
- `redirect_pc` in 32: redirect target byte address.
- `rom_addr` out ADDR_W: word index to the ROM; combinational.
- `rom_instr` in 32: ROM registered output for the address presented last cycle.
- `if_valid` out 1: fetch output is a real instruction.
- `if_pc` out 32: byte PC of `if_instr`.
- `if_instr` out 32: instruction to decode.
- `misalign_err` out 1: sticky; a redirect target had `[1:0] != 0`.
- `fetch_count` out 32: number of cycles in which a new instruction was delivered.

## Operation
- Registers:
  - `pc_q` is the next PC to fetch.
  - `if_pc_q` is the PC of the word currently on `rom_instr`.
  - `valid_q` marks whether that word is real.
  - `misalign_q` is the sticky misalignment flag.
  - `cnt_q` is the delivered-instruction counter.
- `rom_addr` select, in priority order:
  1. `redirect_valid`: `redirect_pc[ADDR_W+1:2]`.
  2. `stall && valid_q`: `if_pc_q[ADDR_W+1:2]` (replay, so `rom_instr` stays stable).
  3. Otherwise: `pc_q[ADDR_W+1:2]`.
- Update at each posedge, in priority order:
  1. Redirect:
     - `tgt = {redirect_pc[31:2], 2'b00}`.
     - `if_pc_q <= tgt`, `pc_q <= tgt + 4`, `valid_q <= 1`.
     - If `redirect_pc[1:0] != 0`, set `misalign_q`.
  2. `stall && valid_q`: all registers hold.
  3. Advance: `if_pc_q <= pc_q`, `pc_q <= pc_q + 4`, `valid_q <= 1`.
- Stall while `valid_q = 0` is ignored; a bubble needs no holding.
- Outputs:
  - `if_valid = valid_q`.
  - `if_pc = if_pc_q`.
  - `if_instr = valid_q ? rom_instr : 32'h0000_0013` (NOP mask; the ROM output is undefined after reset).
- Counter: `cnt_q` increments on every posedge where the new `valid_q` is 1 and the cycle was not a held stall.
- Arithmetic:
  - `pc_q + 4` wraps modulo 2^32.
  - The ROM index uses only bits `[ADDR_W+1:2]`, so index 1023 is followed by index 0.
  - `if_pc` still reports the full 32-bit value.
- Redirect beats stall in the same cycle.
- The word being output when redirect fires is wrong-path. Squashing it is the downstream flush's job; this block does not revoke it.

## Timing
- Reset (async assert; synchronous deassert is handled externally):
  - `pc_q = PC_RESET`, `if_pc_q = 0`, `valid_q = 0`, `misalign_q = 0`, `cnt_q = 0`.
  - Outputs: `if_valid = 0`, `if_pc = 0`, `if_instr = 32'h13`, `misalign_err = 0`, `fetch_count = 0`.
- Boot: the first posedge after deassert latches `PC_RESET`. From the next cycle, `if_valid = 1` and `if_pc = PC_RESET`. One bubble total.
- Steady state: address presented in cycle N produces `if_instr` in cycle N+1. Throughput is one instruction per cycle.
- Stall asserted in cycle t:
  - Outputs hold from cycle t through the stall.
  - At release in cycle u, the held word is consumed in u and PC+4 appears in u+1. No loss, no duplicate.
- Redirect in cycle t: `if_pc = tgt` and `if_instr = ROM[tgt>>2]` in cycle t+1, valid. Zero-bubble redirect.
- Reset mid-stream: outputs drop to reset values immediately (async); any in-flight ROM word is discarded by the mask.

## Test plan
- Reset then run, ROM[0..2] = 00150393, 00248413, 008385B3 -> `if_valid` 0 for the first cycle. Then `if_pc` = 0, 4, 8 on consecutive cycles with matching `if_instr`; `fetch_count` = 3.
- Stall for 3 cycles while `if_pc = 4` -> `if_pc = 4` and `if_instr = 00248413` held for 3 cycles. `if_pc = 8` on the cycle after release; `fetch_count` is not incremented during the stall.
- Redirect to 0x18 while `if_pc = 8` -> next cycle `if_pc = 0x18` and `if_instr = 00338A13`; the cycle after that `if_pc = 0x1C`.
- Redirect and stall in the same cycle, target 0x0 -> redirect wins; next cycle `if_pc = 0`, `if_instr = 00150393`.
- Redirect to 0x0000_0FFE -> `misalign_err` is 1 and stays set. `if_pc = 0xFFC` (ROM index 1023); next `if_pc = 0x1000` with ROM index 0 (wrap).
- Assert `rst_n` low mid-run for half a cycle -> `if_valid`, `if_pc` and `fetch_count` go to 0 immediately and `if_instr = 00000013`. Fetch restarts at `PC_RESET`.
